// File: rtl/reset_seq_ctrl.sv
// reset_seq_ctrl: multi-channel active-low reset sequencer with POR hold, staggered release
// and software reset pulses. Define RESET_SEQ_CNT_EN to add the per-channel sw_rst_cnt counters.
module reset_seq_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int POR_HOLD = 100,
    parameter int STAGGER  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   sw_rst_req,
    input  logic [CNT_W-1:0]    sw_rst_len,
    output logic [NUM_CH-1:0]   rst_out_n,
    output logic                busy,
    output logic                seq_done
`ifdef RESET_SEQ_CNT_EN
    ,
    output logic [NUM_CH*8-1:0] sw_rst_cnt
`endif
);

    localparam logic [2:0] ST_POR     = 3'd0;
    localparam logic [2:0] ST_HOLD    = 3'd1;
    localparam logic [2:0] ST_RELEASE = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_ASSERT  = 3'd4;

    localparam int              GAP_W    = $clog2(STAGGER + 2);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(STAGGER);

    logic [2:0]        state;
    logic              sync1;
    logic              sync2;
    logic [CNT_W-1:0]  hold;
    logic [GAP_W-1:0]  gap;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] req_all;
    logic [NUM_CH-1:0] low_bit;
    logic [NUM_CH-1:0] rel_now;
    logic [NUM_CH-1:0] mask_left;
    logic [CNT_W-1:0]  len_eff;
    logic              rel_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= 1'b1;
            sync2 <= sync1;
        end
    end

    // The first release happens on the same edge the hold count expires, so a
    // pulse of length N keeps its channels low for exactly N cycles.
    assign req_all   = sw_rst_req | pending;
    assign low_bit   = mask & (~mask + NUM_CH'(1));
    assign rel_now   = (STAGGER == 0) ? mask : low_bit;
    assign mask_left = mask & ~rel_now;
    assign len_eff   = (sw_rst_len == '0) ? CNT_W'(1) : sw_rst_len;
    assign rel_fire  = ((state == ST_HOLD) && (hold <= CNT_W'(1))) ||
                       ((state == ST_RELEASE) && (gap == '0));
    assign busy      = (state != ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_POR;
            hold      <= '0;
            gap       <= '0;
            mask      <= '1;
            pending   <= '0;
            rst_out_n <= '0;
            seq_done  <= 1'b0;
        end else begin
            seq_done <= 1'b0;
            if (state != ST_RUN) begin
                pending <= pending | sw_rst_req;
            end
            case (state)
                ST_POR: begin
                    if (sync2) begin
                        hold  <= CNT_W'(POR_HOLD);
                        mask  <= '1;
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD, ST_RELEASE: begin
                    if (rel_fire) begin
                        rst_out_n <= rst_out_n | rel_now;
                        mask      <= mask_left;
                        gap       <= GAP_LOAD;
                        if (mask_left == '0) begin
                            seq_done <= 1'b1;
                            state    <= ST_RUN;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end else if (state == ST_HOLD) begin
                        hold <= hold - CNT_W'(1);
                    end else begin
                        gap <= gap - GAP_W'(1);
                    end
                end
                ST_RUN: begin
                    if (req_all != '0) begin
                        mask    <= req_all;
                        pending <= '0;
                        hold    <= len_eff;
                        state   <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    rst_out_n <= rst_out_n & ~mask;
                    state     <= ST_HOLD;
                end
                default: begin
                    state <= ST_POR;
                end
            endcase
        end
    end

`ifdef RESET_SEQ_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_rst_cnt <= '0;
        end else if (state == ST_RUN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (req_all[i] && (sw_rst_cnt[i*8 +: 8] != 8'hFF)) begin
                    sw_rst_cnt[i*8 +: 8] <= sw_rst_cnt[i*8 +: 8] + 8'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Self-checking bench for reset_seq_ctrl: directed scenarios plus random requests, checked
// every cycle against an event-schedule model. Define RESET_SEQ_CNT_EN to also check sw_rst_cnt.
module tb_reset_seq_ctrl;

    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 16;
    localparam int POR_HOLD = 100;
    localparam int STAGGER  = 2;
    localparam int NEVER    = 32'h3FFF_FFFF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] sw_rst_req = '0;
    logic [CNT_W-1:0]  sw_rst_len = '0;
    logic [NUM_CH-1:0] rst_out_n;
    logic              busy;
    logic              seq_done;
`ifdef RESET_SEQ_CNT_EN
    logic [NUM_CH*8-1:0] sw_rst_cnt;
`endif

    reset_seq_ctrl #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .POR_HOLD (POR_HOLD),
        .STAGGER  (STAGGER)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_rst_req (sw_rst_req),
        .sw_rst_len (sw_rst_len),
        .rst_out_n  (rst_out_n),
        .busy       (busy),
        .seq_done   (seq_done)
`ifdef RESET_SEQ_CNT_EN
        ,
        .sw_rst_cnt (sw_rst_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: each sequence is a schedule of release edges computed arithmetically.
    int              cyc = 0;
    int              low_from = -1;
    int              rel_at [NUM_CH];
    int              done_at = NEVER;
    logic [NUM_CH-1:0] seq_mask = '1;
    logic [NUM_CH-1:0] m_pend = '0;
    bit              por_wait = 1'b1;
    int              por_e0 = 0;
    int              m_len;
    int              m_k;

    int              low_cnt [NUM_CH];
    int              done_cnt = 0;
    int              last_done_cyc = 0;
    logic [NUM_CH-1:0] e_out;
    logic            e_busy;
    logic            e_done;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            m_pend   = '0;
            seq_mask = '1;
            low_from = -1;
            for (int i = 0; i < NUM_CH; i++) rel_at[i] = NEVER;
            done_at  = NEVER;
            por_wait = 1'b1;
        end else if (por_wait) begin
            por_wait = 1'b0;
            por_e0   = cyc;
            for (int i = 0; i < NUM_CH; i++) rel_at[i] = cyc + 2 + POR_HOLD + i * (STAGGER + 1);
            done_at  = rel_at[NUM_CH-1];
            seq_mask = '1;
            low_from = -1;
            m_pend   = m_pend | sw_rst_req;
        end else if ((cyc > done_at) && ((sw_rst_req | m_pend) != '0)) begin
            m_len    = (sw_rst_len == '0) ? 1 : int'(sw_rst_len);
            seq_mask = sw_rst_req | m_pend;
            m_pend   = '0;
            low_from = cyc + 1;
            m_k      = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (seq_mask[i]) begin
                    rel_at[i] = cyc + 1 + m_len + m_k * (STAGGER + 1);
                    done_at   = rel_at[i];
                    m_k++;
                end
            end
        end else if (cyc <= done_at) begin
            m_pend = m_pend | sw_rst_req;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            e_out  = '0;
            e_busy = 1'b1;
            e_done = 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                e_out[i] = !(seq_mask[i] && (cyc >= low_from) && (cyc < rel_at[i]));
            e_busy = (cyc < done_at);
            e_done = (cyc == done_at);
        end
        checkOutput("outs", 32'({rst_out_n, busy, seq_done}), 32'({e_out, e_busy, e_done}));
        if (rst_n) begin
            for (int i = 0; i < NUM_CH; i++) if (!rst_out_n[i]) low_cnt[i]++;
            if (seq_done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic [NUM_CH-1:0] req, input logic [CNT_W-1:0] len);
        sw_rst_req = req;
        sw_rst_len = len;
        @(posedge clk);
        #2;
        sw_rst_req = '0;
    endtask

    task automatic clearMon();
        for (int i = 0; i < NUM_CH; i++) low_cnt[i] = 0;
        done_cnt = 0;
    endtask

    task automatic waitIdle(input int bound);
        int quiet;
        quiet = 0;
        for (int n = 0; (n < bound) && (quiet < 2); n++) begin
            @(posedge clk);
            #2;
            if (busy) quiet = 0;
            else quiet++;
        end
        if (quiet < 2) checkOutput("wait_idle", 32'(quiet), 32'd2);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] start");
        clearMon();
        idleCycles(5);
        rst_n = 1'b1;
        waitIdle(300);
        checkOutput("por_done_cycle", 32'(last_done_cyc - por_e0), 32'd111);

        clearMon();
        applyStimulus(4'b0100, 16'd10);
        waitIdle(100);
        checkOutput("single_len", 32'(low_cnt[2]), 32'd10);
        checkOutput("single_others", 32'(low_cnt[0] + low_cnt[1] + low_cnt[3]), 32'd0);
        checkOutput("single_done", 32'(done_cnt), 32'd1);

        clearMon();
        applyStimulus(4'b0001, 16'd20);
        idleCycles(4);
        applyStimulus(4'b1000, 16'd3);
        waitIdle(200);
        checkOutput("overlap_ch0", 32'(low_cnt[0]), 32'd20);
        checkOutput("overlap_ch3", 32'(low_cnt[3]), 32'd3);
        checkOutput("overlap_done", 32'(done_cnt), 32'd2);

        clearMon();
        applyStimulus(4'b0010, 16'd0);
        waitIdle(100);
        checkOutput("len_zero", 32'(low_cnt[1]), 32'd1);

        clearMon();
        applyStimulus(4'b1111, 16'd5);
        waitIdle(100);
        checkOutput("all_ch0", 32'(low_cnt[0]), 32'd5);
        checkOutput("all_ch3", 32'(low_cnt[3]), 32'd14);
        checkOutput("all_done", 32'(done_cnt), 32'd1);

        clearMon();
        applyStimulus(4'b0100, 16'hFFFF);
        waitIdle(70000);
        checkOutput("len_max", 32'(low_cnt[2]), 32'd65535);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 5) == 0) sw_rst_req = 4'($urandom_range(1, 15));
            else sw_rst_req = '0;
            sw_rst_len = 16'($urandom_range(0, 8));
            @(posedge clk);
            #2;
        end
        sw_rst_req = '0;
        waitIdle(2000);

        applyStimulus(4'b0001, 16'd30);
        idleCycles(5);
        applyStimulus(4'b0010, 16'd4);
        idleCycles(5);
        rst_n = 1'b0;
        #1;
        checkOutput("async_out", 32'(rst_out_n), 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd1);
        checkOutput("async_done", 32'(seq_done), 32'd0);
        @(posedge clk);
        #2;
        idleCycles(2);
        rst_n = 1'b1;
        waitIdle(300);
        checkOutput("por2_done_cycle", 32'(last_done_cyc - por_e0), 32'd111);
        clearMon();
        idleCycles(30);
        checkOutput("no_stale_pulse", 32'(low_cnt[0] + low_cnt[1] + low_cnt[2] + low_cnt[3]), 32'd0);
        checkOutput("no_stale_done", 32'(done_cnt), 32'd0);

`ifdef RESET_SEQ_CNT_EN
        for (int n = 0; n < 300; n++) begin
            applyStimulus(4'b0010, 16'd0);
            waitIdle(50);
        end
        checkOutput("sw_rst_cnt", sw_rst_cnt, 32'h0000_FF00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
